// File: rtl/bitwise_pkg.sv
// Shared types for the bitwise logic unit: operation codes and controller states.
package bitwise_pkg;

  localparam int OPW = 3;

  typedef enum logic [OPW-1:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_XNOR = 3'b011,
    OP_NAND = 3'b100,
    OP_NOR  = 3'b101,
    OP_NOTX = 3'b110,
    OP_ANDN = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/logic_slice.sv
// Combinational CHUNK-bit slice: applies one logic op and reports the slice's
// parity and number of set bits.
module logic_slice
  import bitwise_pkg::*;
#(
  parameter  int CHUNK = 4,
  localparam int SPW   = $clog2(CHUNK + 1)
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  op_e              op,
  output logic [CHUNK-1:0] r,
  output logic             par,
  output logic [SPW-1:0]   pop
);

  always_comb begin
    // NOTE: every output gets a default before the case/loop so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    r   = '0;
    pop = '0;
    unique case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_XNOR: r = ~(a ^ b);
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_NOTX: r = ~a;
      OP_ANDN: r = a & ~b;
    endcase
    par = ^r;
    for (int i = 0; i < CHUNK; i++) begin
      pop = pop + SPW'(r[i]);
    end
  end

endmodule

// File: rtl/bitwise_logic_unit.sv
// Multi-cycle bitwise logic unit: applies one of eight logic ops CHUNK bits per
// cycle (LSB chunk first) and reports zero, parity and popcount of the result.
module bitwise_logic_unit
  import bitwise_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int CHUNK = 4,
  localparam int PCW   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [OPW-1:0]   op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             parity,
  output logic [PCW-1:0]   popcnt
);

  localparam int NCHUNK = (CHUNK >= 1) ? WIDTH / CHUNK : 1;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int SPW    = $clog2(CHUNK + 1);

  if (CHUNK < 1) begin : g_bad_chunk
    $error("bitwise_logic_unit: CHUNK must be at least 1");
  end else if (WIDTH % CHUNK != 0) begin : g_bad_split
    $error("bitwise_logic_unit: WIDTH must be a multiple of CHUNK");
  end

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q;
  logic [WIDTH-1:0] x_q, y_q;
  op_e              op_q;
  logic [WIDTH-1:0] result_q, result_next;
  logic             zero_q, parity_q;
  logic [PCW-1:0]   popcnt_q;

  logic [CHUNK-1:0] slice_r;
  logic             slice_par;
  logic [SPW-1:0]   slice_pop;
  logic             last_chunk;
  logic             accept;

  assign accept     = (state_q == S_IDLE) && in_valid;
  assign last_chunk = (k_q == KW'(NCHUNK - 1));

  logic_slice #(.CHUNK(CHUNK)) u_slice (
    .a   (x_q[k_q*CHUNK +: CHUNK]),
    .b   (y_q[k_q*CHUNK +: CHUNK]),
    .op  (op_q),
    .r   (slice_r),
    .par (slice_par),
    .pop (slice_pop)
  );

  always_comb begin
    result_next = result_q;
    result_next[k_q*CHUNK +: CHUNK] = slice_r;
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (in_valid)   state_d = S_RUN;
      S_RUN:  if (last_chunk) state_d = S_DONE;
      S_DONE: if (out_ready)  state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  // NOTE: the operand copies carry no reset; they are only read after a
  // capture has written them, so reset would only add load on rst.
  always_ff @(posedge clk) begin
    if (accept) begin
      x_q  <= x;
      y_q  <= y;
      op_q <= op_e'(op);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      zero_q   <= 1'b0;
      parity_q <= 1'b0;
      popcnt_q <= '0;
      k_q      <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (in_valid) begin
          result_q <= '0;
          zero_q   <= 1'b0;
          parity_q <= 1'b0;
          popcnt_q <= '0;
          k_q      <= '0;
        end
        S_RUN: begin
          result_q <= result_next;
          parity_q <= parity_q ^ slice_par;
          popcnt_q <= popcnt_q + PCW'(slice_pop);
          if (last_chunk) begin
            k_q    <= '0;
            zero_q <= (result_next == '0);
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        // zero only reflects a result while it is being presented.
        S_DONE: if (out_ready) zero_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign result = result_q;
  assign zero   = zero_q;
  assign parity = parity_q;
  assign popcnt = popcnt_q;

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Scoreboard bench for bitwise_logic_unit: directed and random ops on 16/4, plus
// random sweeps on 16/16 and 8/2, checked against a whole-word reference model.
module tb_bitwise_logic_unit;

  typedef struct {
    logic [15:0] res;
    logic        zero;
    logic        par;
    int          pop;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] res, input logic z, input logic p, input int pop);
    exp_t e;
    e.res = res; e.zero = z; e.par = p; e.pop = pop; e.acc = 0;
    return e;
  endfunction

  // Reference: whole-word logic op, masked to the operand width.
  function automatic exp_t model(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                                 input int w);
    logic [15:0] r;
    logic [15:0] mask;
    exp_t        e;
    mask = (w >= 16) ? 16'hFFFF : ((16'd1 << w) - 16'd1);
    case (o)
      3'd0:    r = a & b;
      3'd1:    r = a | b;
      3'd2:    r = a ^ b;
      3'd3:    r = ~(a ^ b);
      3'd4:    r = ~(a & b);
      3'd5:    r = ~(a | b);
      3'd6:    r = ~a;
      default: r = a & ~b;
    endcase
    r = r & mask;
    e.res  = r;
    e.pop  = $countones(r);
    e.zero = (r == 16'd0);
    e.par  = e.pop[0];
    e.acc  = 0;
    return e;
  endfunction

  // ---------------- main instance: WIDTH=16, CHUNK=4 ----------------
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] x, y, result;
  logic [2:0]  op;
  logic        zero, parity;
  logic [4:0]  popcnt;
  logic        rand_ready, force_ready, rnd_bit;

  always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));
  assign out_ready = rand_ready ? rnd_bit : force_ready;

  bitwise_logic_unit #(.WIDTH(16), .CHUNK(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .parity    (parity),
    .popcnt    (popcnt)
  );

  exp_t q0[$];
  bit   seen0 = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      seen0 = 1'b0;
    end else if (out_valid) begin
      if (q0.size() == 0) begin
        check("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        if (!seen0) begin
          check("latency", cyc - q0[0].acc, 32'd4);
          seen0 = 1'b1;
        end
        check("result", result, q0[0].res);
        check("zero", zero, q0[0].zero);
        check("parity", parity, q0[0].par);
        check("popcnt", popcnt, q0[0].pop);
        check("in_ready_in_done", in_ready, 32'd0);
        if (out_ready) begin
          void'(q0.pop_front());
          seen0 = 1'b0;
        end
      end
    end else begin
      check("zero_outside_done", zero, 32'd0);
    end
  end

  // Called just after a rising edge; leaves the bench just after a rising edge.
  task automatic send0(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                       input exp_t e);
    bit done;
    done = 1'b0;
    op = o; x = a; y = b; in_valid = 1'b1;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        e.acc = cyc + 1;
        q0.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    x = 16'($urandom); y = 16'($urandom); op = 3'($urandom);
    if (!done) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain0();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 500 && !done; t++) begin
      @(posedge clk); #1;
      done = (q0.size() == 0) && !out_valid;
    end
    if (!done) check("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    @(negedge clk);
    check({tag, "_in_ready"}, in_ready, 32'd1);
    check({tag, "_out_valid"}, out_valid, 32'd0);
    check({tag, "_result"}, result, 32'd0);
    check({tag, "_zero"}, zero, 32'd0);
    check({tag, "_parity"}, parity, 32'd0);
    check({tag, "_popcnt"}, popcnt, 32'd0);
  endtask

  // ---------------- sweep instances: 16/16 and 8/2 ----------------
  for (genvar g = 0; g < 2; g++) begin : g_sweep
    localparam int W = (g == 0) ? 16 : 8;
    localparam int C = (g == 0) ? 16 : 2;
    localparam int N = W / C;
    localparam int P = $clog2(W + 1);

    logic         srst, siv, sir, sov, sor, szero, spar;
    logic [W-1:0] sx, sy, sres;
    logic [2:0]   sop;
    logic [P-1:0] spop;
    exp_t         sq[$];
    bit           sseen = 1'b0;
    bit           sdone = 1'b0;

    always @(posedge clk) sor <= 1'($urandom_range(0, 1));

    bitwise_logic_unit #(.WIDTH(W), .CHUNK(C)) u_dut (
      .clk       (clk),
      .rst       (srst),
      .in_valid  (siv),
      .in_ready  (sir),
      .x         (sx),
      .y         (sy),
      .op        (sop),
      .out_valid (sov),
      .out_ready (sor),
      .result    (sres),
      .zero      (szero),
      .parity    (spar),
      .popcnt    (spop)
    );

    always @(negedge clk) begin
      if (srst) begin
        sseen = 1'b0;
      end else if (sov) begin
        if (sq.size() == 0) begin
          check($sformatf("w%0d_c%0d_unexpected_out_valid", W, C), 32'd1, 32'd0);
        end else begin
          if (!sseen) begin
            check($sformatf("w%0d_c%0d_latency", W, C), cyc - sq[0].acc, N);
            sseen = 1'b1;
          end
          check($sformatf("w%0d_c%0d_result", W, C), sres, sq[0].res);
          check($sformatf("w%0d_c%0d_zero", W, C), szero, sq[0].zero);
          check($sformatf("w%0d_c%0d_parity", W, C), spar, sq[0].par);
          check($sformatf("w%0d_c%0d_popcnt", W, C), spop, sq[0].pop);
          if (sor) begin
            void'(sq.pop_front());
            sseen = 1'b0;
          end
        end
      end
    end

    initial begin
      srst = 1'b1; siv = 1'b0; sx = '0; sy = '0; sop = '0;
      repeat (3) @(posedge clk);
      #1 srst = 1'b0;
      for (int i = 0; i < 1000; i++) begin
        logic [15:0] a, b;
        logic [2:0]  o;
        exp_t        e;
        bit          acc;
        a = 16'($urandom); b = 16'($urandom); o = 3'($urandom);
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        e = model(o, a, b, W);
        sx = a[W-1:0]; sy = b[W-1:0]; sop = o; siv = 1'b1; acc = 1'b0;
        for (int t = 0; t < 100 && !acc; t++) begin
          @(negedge clk);
          if (sir) begin
            e.acc = cyc + 1;
            sq.push_back(e);
            acc = 1'b1;
          end
          @(posedge clk); #1;
        end
        siv = 1'b0;
        if (!acc) check($sformatf("w%0d_c%0d_accept_timeout", W, C), 32'd0, 32'd1);
      end
      for (int t = 0; t < 500 && (sq.size() != 0 || sov); t++) begin
        @(posedge clk); #1;
      end
      if (sq.size() != 0) check($sformatf("w%0d_c%0d_drain_timeout", W, C), sq.size(), 32'd0);
      sdone = 1'b1;
    end
  end

  // ---------------- directed and random sequence on the main instance ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; x = '0; y = '0; op = '0;
    force_ready = 1'b1; rand_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_values("reset");
    @(posedge clk); #1;

    send0(3'b010, 16'hA5A5, 16'h0FF0, mk(16'hAA55, 1'b0, 1'b0, 8));
    drain0();
    send0(3'b000, 16'h1234, 16'h0000, mk(16'h0000, 1'b1, 1'b0, 0));
    send0(3'b110, 16'h0000, 16'h5A5A, mk(16'hFFFF, 1'b0, 1'b0, 16));
    send0(3'b101, 16'h1234, 16'h0000, mk(16'hEDCB, 1'b0, 1'b1, 11));
    drain0();

    // Backpressure: outputs held while out_ready is low and inputs wiggle.
    force_ready = 1'b0;
    send0(3'b010, 16'hA5A5, 16'h0FF0, mk(16'hAA55, 1'b0, 1'b0, 8));
    for (int t = 0; t < 20 && !out_valid; t++) begin @(posedge clk); #1; end
    check("bp_reached_done", out_valid, 32'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      x = 16'($urandom);
      @(negedge clk);
      check("bp_in_ready", in_ready, 32'd0);
      check("bp_out_valid", out_valid, 32'd1);
      @(posedge clk); #1;
    end
    // Simultaneous in_valid and out_ready in DONE: only the output side completes.
    in_valid = 1'b1;
    force_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_release_in_ready", in_ready, 32'd1);
    check("bp_release_out_valid", out_valid, 32'd0);
    check("bp_queue_empty", q0.size(), 32'd0);
    @(posedge clk); #1;

    // Reset during the second RUN cycle aborts the operation.
    x = 16'hFFFF; y = 16'h0000; op = 3'b010; in_valid = 1'b1;
    @(negedge clk);
    check("abort_accept_ready", in_ready, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_values("abort");
    @(posedge clk); #1;
    send0(3'b010, 16'hFFFF, 16'h00FF, mk(16'hFF00, 1'b0, 1'b0, 8));
    drain0();

    // Random ops with random backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [15:0] a, b;
      logic [2:0]  o;
      a = 16'($urandom); b = 16'($urandom); o = 3'($urandom);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send0(o, a, b, model(o, a, b, 16));
    end
    drain0();

    for (int t = 0; t < 60000 && !(g_sweep[0].sdone && g_sweep[1].sdone); t++) @(posedge clk);
    check("sweep_finished", {30'd0, g_sweep[1].sdone, g_sweep[0].sdone}, 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "simulation watchdog expired");
  end

endmodule

// File: doc/bitwise_logic_unit.md
# bitwise_logic_unit

Parametrised, multi-cycle bitwise logic unit for the calculator datapath. It generalises the fixed 16-bit XOR stage to any operand width and eight selectable logic operations. It processes operands CHUNK bits per cycle and reports result flags (zero, parity, popcount). It sits behind the operand/opcode decoder and in front of the result mux and display formatter, with valid/ready handshakes on both sides.

## Interface
- WIDTH, 16, operand and result width in bits (≥1)
- CHUNK, 4, bits processed per RUN cycle; WIDTH % CHUNK must be 0; NCHUNK = WIDTH/CHUNK
- PCW, $clog2(WIDTH+1), popcount width (derived, not overridable)

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  operands and op valid
- in_ready  out  1  unit can accept; high only in IDLE
- x  in  WIDTH  operand A
- y  in  WIDTH  operand B (ignored for NOTX)
- op  in  3  operation select (see Operation)
- out_valid  out  1  result and flags valid; high only in DONE
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  registered result
- zero  out  1  result == 0
- parity  out  1  XOR-reduction of result
- popcnt  out  PCW  number of 1 bits in result

## Operation
- Opcodes: 000 AND, 001 OR, 010 XOR, 011 XNOR, 100 NAND, 101 NOR, 110 NOTX (~x), 111 ANDN (x & ~y). All eight are defined; there is no illegal opcode.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid, latch x, y and op into internal registers. Clear result, parity and popcnt. Set chunk index k=0. Go to RUN.
  - RUN: each cycle apply op to bits [k*CHUNK +: CHUNK] of the latched operands (LSB chunk first). Write those bits of result. Accumulate parity ^= reduce-XOR(slice) and popcnt += ones(slice). Increment k. When k reaches NCHUNK-1, go to DONE on that edge.
  - DONE: out_valid=1. result, zero, parity and popcnt are stable. On out_ready, go to IDLE.
- zero is registered on the RUN→DONE edge from the complete result; it is 0 outside DONE.
- Inputs x, y and op may change freely after acceptance; only the latched copies are used.
- in_valid outside IDLE is ignored (no capture, no queueing).
- Popcount accumulator is PCW bits wide; WIDTH ones never overflow it.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, result=0, zero=0, parity=0, popcnt=0, k=0.
- Accept edge E0 (in_valid & in_ready).
- RUN occupies cycles E0+1 … E0+NCHUNK.
- out_valid rises on edge E0+NCHUNK: latency NCHUNK cycles. Example: WIDTH=16, CHUNK=4 gives 4 cycles; CHUNK=WIDTH gives 1 cycle.
- Output handshake edge D (out_valid & out_ready): out_valid=0 and in_ready=1 from D onward. Earliest next accept is edge D+1.
- Throughput: one op per NCHUNK+2 cycles with out_ready held high.
- Backpressure: DONE holds all outputs unchanged indefinitely while out_ready=0.
- Reset in any state, including mid-RUN or DONE, wins over everything. It aborts and discards the operation, and all outputs return to reset values on the reset edge.
- Simultaneous in_valid and out_ready in DONE: only the output handshake completes; the input is not captured.

## Structure
- Shared package bitwise_pkg: op enum (OP_AND … OP_ANDN), fsm state enum, opcode width constant (3).
- One sub-module: logic_slice. It is combinational and CHUNK bits wide. Inputs are two slices and op; outputs are the result slice, slice parity and slice popcount. It is instantiated once in bitwise_logic_unit.
- Elaboration-time check: error if WIDTH % CHUNK != 0 or CHUNK < 1.

## Test plan
All scenarios use WIDTH=16, CHUNK=4 unless noted.
- XOR: x=0xA5A5, y=0x0FF0, op=010 → out_valid exactly 4 cycles after accept. result=0xAA55, popcnt=8, parity=0, zero=0.
- AND to zero: x=0x1234, y=0x0000, op=000 → result=0x0000, zero=1, popcnt=0, parity=0. NOTX x=0x0000 → result=0xFFFF, popcnt=16, parity=0.
- NOR: x=0x1234, y=0x0000, op=101 → result=0xEDCB, popcnt=11, parity=1, zero=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and x → result and flags stable, in_ready=0, no capture. Raise out_ready → in_ready=1 the next cycle.
- Reset mid-RUN: assert rst at the second RUN cycle → next cycle all outputs at reset values, in_ready=1. A new XOR of 0xFFFF ^ 0x00FF completes with result=0xFF00.
- Parameter sweep: CHUNK=16 with WIDTH=16, and WIDTH=8 with CHUNK=2 → latency 1 and 4 cycles respectively. Results match the reference model over 1000 random ops with random out_ready.
